tile_pixel_engine: RTL and testbench

//  Parametrised tile/pattern renderer. Successor to the fixed 8x8, 2-bpp SPI video memory.

---
 rtl/tile_video_pkg.sv | 20 ++
 rtl/tile_pixel_engine_if.sv | 12 +
 rtl/tile_video_ram.sv | 24 ++
 rtl/tile_pixel_engine.sv | 181 ++++++++++++++++++
 tb/tb_tile_pixel_engine.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tile_video_pkg.sv
// tile_video_pkg: command encoding and geometry constants shared by the tile pixel engine
//   tgt_e      : write-command target codes carried in cmd_data[31:30]
//   CMD_*      : bit positions/widths of the command fields
//   TILE_DIM   : tile edge in pixels
//   RGB565_W   : width of an output pixel
package tile_video_pkg;
    typedef enum logic [1:0] {
        TGT_PATTERN = 2'b00,
        TGT_MAP     = 2'b01,
        TGT_PALETTE = 2'b10,
        TGT_SCROLL  = 2'b11
    } tgt_e;
    localparam int CMD_W        = 32;
    localparam int CMD_TGT_LSB  = 30;
    localparam int CMD_ADDR_LSB = 16;
    localparam int CMD_ADDR_W   = 14;
    localparam int CMD_DATA_W   = 16;
    localparam int TILE_DIM     = 8;
    localparam int RGB565_W     = 16;
endpackage

// File: rtl/tile_pixel_engine_if.sv
// tile_pixel_engine_if: valid/ready write-command stream into the tile pixel engine
//   cmd_valid : command present (master)
//   cmd_ready : command taken this cycle when both are high (slave)
//   cmd_data  : {target[1:0], addr[13:0], data[15:0]} (master)
interface tile_pixel_engine_if;
    import tile_video_pkg::*;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_data;
    modport master (output cmd_valid, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/tile_video_ram.sv
// tile_video_ram: synchronous read-first RAM with one write port and one registered read port
//   clk               : clock
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : read port; rdata holds the last read until the next re
//   A same-cycle write to the read address returns the old word.
module tile_video_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/tile_pixel_engine.sv
// tile_pixel_engine: tile-map/pattern renderer producing one RGB565 pixel per PIXEL_CLKS clocks
//   clk, reset (async, active-low)
//   cmd                : write-command stream (tile_pixel_engine_if.slave)
//   display_x/y        : coordinates of the pixel to render, sampled at slot phase 0
//   in_display_region  : coordinates are visible
//   dotclk, posclk     : panel pixel clock and position-counter advance strobe
//   pixel_out          : RGB565 pixel, pixel_valid marks a rendered visible pixel
//   Macro PALETTE_EN: when defined a 16-entry palette maps pixel indices to colours;
//   otherwise the index itself is output zero-extended.
module tile_pixel_engine
    import tile_video_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int BPP            = 2,
    parameter int MAP_COLS       = 32,
    parameter int MAP_ROWS       = 64,
    parameter int PIXEL_CLKS     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    tile_pixel_engine_if.slave                cmd,
    input  logic [$clog2(DISPLAY_WIDTH)-1:0]  display_x,
    input  logic [$clog2(DISPLAY_HEIGHT)-1:0] display_y,
    input  logic                              in_display_region,
    output logic                              dotclk,
    output logic                              posclk,
    output logic [RGB565_W-1:0]               pixel_out,
    output logic                              pixel_valid
);
    localparam int PW        = $clog2(PIXEL_CLKS);
    localparam logic [PW-1:0] LAST = PW'(PIXEL_CLKS - 1);
    localparam int TW        = $clog2(TILE_DIM);
    localparam int SXW       = $clog2(MAP_COLS * TILE_DIM);
    localparam int SYW       = $clog2(MAP_ROWS * TILE_DIM);
    localparam int WPR       = BPP / 2;
    localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
    localparam int PAT_DEPTH = 256 * TILE_DIM * WPR;
    localparam int MAW       = $clog2(MAP_DEPTH);
    localparam int PAW       = $clog2(PAT_DEPTH);

    // act stays low until the first edge after reset so that edge opens slot phase 0
    logic          act;
    logic [PW-1:0] phase;
    logic          p0, p1, p2, plast;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act   <= 1'b0;
            phase <= '0;
        end else begin
            act   <= 1'b1;
            phase <= (!act || phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    assign p0     = act && phase == '0;
    assign p1     = act && phase == PW'(1);
    assign p2     = act && phase == PW'(2);
    assign plast  = act && phase == LAST;
    assign posclk = p0;
    assign dotclk = act && phase < PW'(PIXEL_CLKS / 2);

    // In-region the RAM read ports are busy except in the last phase
    tgt_e                  tgt;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdat;
    logic                  fire;

    assign cmd.cmd_ready = act && (!in_display_region || phase == LAST);
    assign fire          = cmd.cmd_valid && cmd.cmd_ready;
    assign tgt           = tgt_e'(cmd.cmd_data[CMD_TGT_LSB +: 2]);
    assign addr          = cmd.cmd_data[CMD_ADDR_LSB +: CMD_ADDR_W];
    assign wdat          = cmd.cmd_data[CMD_DATA_W-1:0];

    // Live scroll takes writes; the active copy only changes at the frame origin
    logic [SXW-1:0] sx_live, sx_act, sx_eff, ex;
    logic [SYW-1:0] sy_live, sy_act, sy_eff, ey;
    logic           frame_start;

    assign frame_start = p0 && display_x == '0 && display_y == '0;
    assign sx_eff      = frame_start ? sx_live : sx_act;
    assign sy_eff      = frame_start ? sy_live : sy_act;
    assign ex          = SXW'(32'(display_x) + 32'(sx_eff));
    assign ey          = SYW'(32'(display_y) + 32'(sy_eff));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sx_live <= '0;
            sy_live <= '0;
            sx_act  <= '0;
            sy_act  <= '0;
        end else begin
            if (fire && tgt == TGT_SCROLL && addr == 14'd0) sx_live <= wdat[SXW-1:0];
            if (fire && tgt == TGT_SCROLL && addr == 14'd1) sy_live <= wdat[SYW-1:0];
            if (frame_start) begin
                sx_act <= sx_live;
                sy_act <= sy_live;
            end
        end
    end

    // Sub-tile position and visibility travel with the slot until its pixel is committed
    logic [TW-1:0] ex_lo, ey_lo;
    logic          vis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_lo <= '0;
            ey_lo <= '0;
            vis_q <= 1'b0;
        end else if (p0) begin
            ex_lo <= ex[TW-1:0];
            ey_lo <= ey[TW-1:0];
            vis_q <= in_display_region;
        end
    end

    logic [7:0] tile;
    tile_video_ram #(.DEPTH(MAP_DEPTH), .WIDTH(8)) u_map (
        .clk   (clk),
        .we    (fire && tgt == TGT_MAP && 32'(addr) < MAP_DEPTH),
        .waddr (addr[MAW-1:0]),
        .wdata (wdat[7:0]),
        .re    (p0),
        .raddr ({ey[SYW-1:TW], ex[SXW-1:TW]}),
        .rdata (tile)
    );

    logic [PAW-1:0]        pat_raddr;
    logic [CMD_DATA_W-1:0] pat_word;
    logic [3:0]            bit_off;
    logic [BPP-1:0]        idx;

    assign pat_raddr = PAW'(32'(tile) * (TILE_DIM * WPR) + 32'(ey_lo) * WPR + ((32'(ex_lo) * BPP) >> 4));
    assign bit_off   = 4'((32'(ex_lo) * BPP) % 16);
    assign idx       = BPP'(pat_word >> bit_off);

    tile_video_ram #(.DEPTH(PAT_DEPTH), .WIDTH(CMD_DATA_W)) u_pat (
        .clk   (clk),
        .we    (fire && tgt == TGT_PATTERN && 32'(addr) < PAT_DEPTH),
        .waddr (addr[PAW-1:0]),
        .wdata (wdat),
        .re    (p1),
        .raddr (pat_raddr),
        .rdata (pat_word)
    );

    logic [RGB565_W-1:0] colour;
`ifdef PALETTE_EN
    tile_video_ram #(.DEPTH(16), .WIDTH(RGB565_W)) u_pal (
        .clk   (clk),
        .we    (fire && tgt == TGT_PALETTE && 32'(addr) < 16),
        .waddr (addr[3:0]),
        .wdata (wdat),
        .re    (p2),
        .raddr (4'(idx)),
        .rdata (colour)
    );
`else
    // Stands in for the palette read stage so latency matches the palette build
    logic [BPP-1:0] idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idx_q <= '0;
        else if (p2) idx_q <= idx;
    end

    assign colour = RGB565_W'(idx_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_out   <= '0;
            pixel_valid <= 1'b0;
        end else if (plast) begin
            pixel_out   <= vis_q ? colour : '0;
            pixel_valid <= vis_q;
        end
    end
endmodule

// File: tb/tb_tile_pixel_engine.sv
// tb_tile_pixel_engine: randomized self-checking bench for tile_pixel_engine against a frame-level model
module tb_tile_pixel_engine;
    localparam int W = 240, H = 320, BPP = 2, MC = 32, MR = 64, PC = 4;
    localparam int WPR = BPP / 2, MAP_D = MC * MR, PAT_D = 256 * 8 * WPR;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  dx;
    logic [8:0]  dy;
    logic        vis;
    logic        dotclk, posclk, pixel_valid;
    logic [15:0] pixel_out;

    tile_pixel_engine_if bus();

    tile_pixel_engine #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .BPP(BPP),
        .MAP_COLS(MC), .MAP_ROWS(MR), .PIXEL_CLKS(PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cmd               (bus),
        .display_x         (dx),
        .display_y         (dy),
        .in_display_region (vis),
        .dotclk            (dotclk),
        .posclk            (posclk),
        .pixel_out         (pixel_out),
        .pixel_valid       (pixel_valid)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;

    // Slot phase from elapsed clocks: the first edge after reset opens phase 0
    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    function automatic int ph();
        return (cyc == 0) ? -1 : (cyc - 1) % PC;
    endfunction

    logic [7:0]  map_m [MAP_D];
    logic [15:0] pat_m [PAT_D];
    logic [15:0] pal_m [16];
    int sxl = 0, syl = 0, sxa = 0, sya = 0;

    function automatic logic [15:0] model_pix(input int x, input int y);
        int ex, ey, tile, bitpos, word, id;
        ex     = (x + sxa) % (MC * 8);
        ey     = (y + sya) % (MR * 8);
        tile   = int'(map_m[(ey / 8) * MC + ex / 8]);
        bitpos = (ex % 8) * BPP;
        word   = int'(pat_m[tile * 8 * WPR + (ey % 8) * WPR + bitpos / 16]);
        id     = (word >> (bitpos % 16)) & ((1 << BPP) - 1);
`ifdef PALETTE_EN
        return pal_m[id];
`else
        return 16'(id);
`endif
    endfunction

    task automatic idle();
        dx  = 8'(W - 1);
        dy  = 9'(H - 1);
        vis = 1'b0;
    endtask

    task automatic sync0();
        for (int n = 0; n < 2 * PC; n++) begin
            @(negedge clk);
            if (ph() == 0) break;
        end
    endtask

    task automatic wr(input logic [1:0] t, input int a, input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        idle();
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {t, a[13:0], d};
        while (!bus.cmd_ready && n < 4 * PC) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL wr_timeout target=%0d addr=%0d ready=0 required=1", t, a);
        end else begin
            @(posedge clk);
            #1;
            case (t)
                2'b00: if (a < PAT_D) pat_m[a] = d;
                2'b01: if (a < MAP_D) map_m[a] = d[7:0];
                2'b10: begin
`ifdef PALETTE_EN
                    if (a < 16) pal_m[a] = d;
`endif
                end
                default: begin
                    if (a == 0) sxl = int'(d) % (MC * 8);
                    else if (a == 1) syl = int'(d) % (MR * 8);
                end
            endcase
        end
        bus.cmd_valid = 1'b0;
    endtask

    // Call at a phase-0 negedge; returns at the next phase-0 negedge
    task automatic slot(input int x, input int y, input logic v, input string nm);
        logic [15:0] exp_p;
        if (x == 0 && y == 0) begin
            sxa = sxl;
            sya = syl;
        end
        exp_p = v ? model_pix(x, y) : 16'h0;
        dx  = x[7:0];
        dy  = y[8:0];
        vis = v;
        repeat (PC) @(negedge clk);
        vectors++;
        if (pixel_out !== exp_p || pixel_valid !== v) begin
            miscompares++;
            $display("FAIL %s (%0d,%0d) pixel=%h valid=%b required pixel=%h valid=%b",
                     nm, x, y, pixel_out, pixel_valid, exp_p, v);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (posclk !== 1'b0) begin miscompares++; $display("FAIL rst_posclk got=%b required=0", posclk); end
        if (dotclk !== 1'b0) begin miscompares++; $display("FAIL rst_dotclk got=%b required=0", dotclk); end
        if (pixel_out !== 16'h0) begin miscompares++; $display("FAIL rst_pixel got=%h required=0", pixel_out); end
        if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b required=0", pixel_valid); end
        if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b required=0", bus.cmd_ready); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (posclk !== 1'b1) begin miscompares++; $display("FAIL first_posclk got=%b required=1", posclk); end
        for (int i = 0; i < PC; i++) begin
            @(negedge clk);
            vectors++;
            if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL slot0_valid got=%b required=0", pixel_valid); end
        end
    endtask

    task automatic test_clocks();
        sync0();
        for (int i = 0; i < 2 * PC; i++) begin
            @(negedge clk);
            vectors += 3;
            if (posclk !== (ph() == 0)) begin miscompares++; $display("FAIL posclk phase=%0d got=%b", ph(), posclk); end
            if (dotclk !== (ph() < PC / 2)) begin miscompares++; $display("FAIL dotclk phase=%0d got=%b", ph(), dotclk); end
            if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_offregion got=%b required=1", bus.cmd_ready); end
        end
    endtask

    task automatic test_init_ram();
        for (int i = 0; i < MAP_D; i++) wr(2'b01, i, 16'($urandom_range(0, 255)));
        for (int i = 0; i < PAT_D; i++) wr(2'b00, i, 16'($urandom));
        for (int i = 0; i < 16; i++) wr(2'b10, i, 16'($urandom));
    endtask

    task automatic test_render();
        wr(2'b01, 0, 16'd5);
        wr(2'b00, 5 * 8 * WPR, 16'h0004);
        wr(2'b10, 1, 16'hF800);
        sync0();
        slot(1, 0, 1'b1, "render_1_0");
`ifndef PALETTE_EN
        vectors++;
        if (pixel_out !== 16'h0001) begin miscompares++; $display("FAIL render_idx got=%h required=0001", pixel_out); end
`endif
        slot(0, 0, 1'b1, "render_0_0");
        slot(7, 0, 1'b0, "render_hidden");
        wr(2'b10, 1, 16'h1234);
        sync0();
        slot(1, 0, 1'b1, "palette_target_write");
        idle();
    endtask

    task automatic test_mid_reset();
        sync0();
        slot(1, 0, 1'b1, "pre_reset");
        @(negedge clk);
        @(negedge clk);
        vis   = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if ({posclk, dotclk, pixel_valid, bus.cmd_ready} !== 4'b0 || pixel_out !== 16'h0)
            begin miscompares++; $display("FAIL midreset_outputs pos=%b dot=%b valid=%b ready=%b pixel=%h required all 0",
                                          posclk, dotclk, pixel_valid, bus.cmd_ready, pixel_out); end
        sxl = 0; syl = 0; sxa = 0; sya = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (posclk !== 1'b1) begin miscompares++; $display("FAIL midreset_posclk got=%b required=1", posclk); end
        for (int i = 0; i < PC; i++) begin
            @(negedge clk);
            vectors++;
            if (pixel_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid got=%b required=0", pixel_valid); end
        end
    endtask

    task automatic test_scroll();
        wr(2'b11, 0, 16'h01FA);
        sync0();
        for (int i = 0; i < 4; i++) slot(10 + 8 * i, 3, 1'b1, "scroll_pre_frame");
        slot(0, 0, 1'b1, "scroll_origin");
        slot(10, 0, 1'b1, "scroll_wrap");
        slot(200, 100, 1'b1, "scroll_x_mid");
        wr(2'b11, 1, 16'd37);
        sync0();
        slot(20, 30, 1'b1, "scroll_y_pre");
        slot(0, 0, 1'b1, "scroll_origin_y");
        slot(20, 30, 1'b1, "scroll_y_post");
        slot(239, 319, 1'b1, "scroll_corner");
        idle();
    endtask

    task automatic test_cmd_ready();
        wr(2'b01, MAP_D - 1, 16'd3);
        for (int w = 0; w < WPR; w++) begin
            wr(2'b00, 3 * 8 * WPR + 7 * WPR + w, 16'h0000);
            wr(2'b00, 4 * 8 * WPR + 7 * WPR + w, 16'hFFFF);
        end
        sync0();
        dx = 8'd5; dy = 9'd5; vis = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {2'b01, 14'h3FFF, 16'h0004};
        for (int i = 0; i < 2 * PC; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.cmd_ready !== (ph() == PC - 1))
                begin miscompares++; $display("FAIL ready_inregion phase=%0d got=%b", ph(), bus.cmd_ready); end
        end
        vis = 1'b0;
        for (int i = 0; i < 2 * PC; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_outregion got=%b required=1", bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b0;
        wr(2'b11, 0, 16'd240);
        wr(2'b11, 1, 16'd500);
        sync0();
        slot(0, 0, 1'b1, "edge_origin");
        for (int i = 0; i < 8; i++) slot(8 + i, 11, 1'b1, "map_addr_drop");
        wr(2'b11, 0, 16'd0);
        wr(2'b11, 1, 16'd0);
        sync0();
        slot(0, 0, 1'b1, "scroll_reset_origin");
        idle();
    endtask

    task automatic test_back_to_back();
        sync0();
        for (int i = 0; i < 30; i++)
            slot($urandom_range(0, W - 1), $urandom_range(0, H - 1), ($urandom_range(0, 3) != 0), "back_to_back");
        idle();
    endtask

    task automatic test_random_writes();
        for (int i = 0; i < 20; i++) begin
            int x, y, ex, ey;
            x  = $urandom_range(0, W - 1);
            y  = $urandom_range(0, H - 1);
            ex = (x + sxa) % (MC * 8);
            ey = (y + sya) % (MR * 8);
            if ($urandom_range(0, 1) == 1) wr(2'b01, (ey / 8) * MC + ex / 8, 16'($urandom_range(0, 255)));
            else wr(2'b00, $urandom_range(0, PAT_D - 1), 16'($urandom));
            sync0();
            slot(x, y, 1'b1, "random_write");
        end
        idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) pal_m[i] = 16'h0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        idle();
        test_reset();
        test_clocks();
        test_init_ram();
        test_render();
        test_mid_reset();
        test_scroll();
        test_cmd_ready();
        test_back_to_back();
        test_random_writes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
